// File: rtl/lif_stdp_pkg.sv
// Shared FSM state type and saturating arithmetic helpers for the LIF/STDP layer.
package lif_stdp_pkg;

   typedef enum logic [2:0] {IDLE, ACCUM, FIRE, LEARN, DONE} state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic [31:0] max_v);
      return (x >= max_v) ? max_v : x + 32'd1;
   endfunction

   function automatic logic [31:0] sat_dec(input logic [31:0] x);
      return (x == 32'd0) ? 32'd0 : x - 32'd1;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max_v}) ? max_v : s[31:0];
   endfunction

endpackage

// File: rtl/lif_stdp_layer_syn.sv
// Next-weight rule for one synapse: LTP on a post spike with a live pre trace,
// otherwise LTD on a pre spike with a live post trace. Clamped, never wraps.
module stdp_syn_update
   import lif_stdp_pkg::*;
#(
   parameter int unsigned W_W = 6,
   parameter int unsigned T_W = 2
)(
   input  logic [W_W-1:0] w_i,
   input  logic           pre_i,
   input  logic [T_W-1:0] pre_trace_i,
   input  logic           post_spk_i,
   input  logic [T_W-1:0] post_trace_i,
   input  logic           learn_en_i,
   output logic [W_W-1:0] w_o
);
   localparam int unsigned W_MAX = 2**W_W - 1;

   always_comb begin
      w_o = w_i;
      if (learn_en_i) begin
         if (post_spk_i && (pre_trace_i != '0))
            w_o = W_W'(sat_inc(32'(w_i), W_MAX));
         else if (pre_i && (post_trace_i != '0))
            w_o = W_W'(sat_dec(32'(w_i)));
      end
   end

endmodule

// File: rtl/lif_stdp_layer.sv
// Single LIF neuron with N_IN trace-STDP synapses, one synapse per cycle.
// Optional adaptive threshold: define LIF_ADAPT_THRESH_EN.
module lif_stdp_layer
   import lif_stdp_pkg::*;
#(
   parameter int unsigned N_IN       = 4,
   parameter int unsigned V_W        = 8,
   parameter int unsigned W_W        = 6,
   parameter int unsigned W_INIT     = 16,
   parameter int unsigned THRESH     = 64,
   parameter int unsigned LEAK_SHIFT = 3,
   parameter int unsigned REFRAC     = 2,
   parameter int unsigned TRACE_MAX  = 3
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    step_valid,
   output logic                    step_ready,
   input  logic [N_IN-1:0]         pre_spk_i,
   input  logic [V_W-1:0]          i_ext,
   input  logic                    learn_en,
   input  logic [$clog2(N_IN)-1:0] w_sel,
   output logic [W_W-1:0]          w_o,
   output logic [V_W-1:0]          v_mem_o,
   output logic                    post_spk_o,
   output logic                    step_done
);
   localparam int unsigned IDX_W = $clog2(N_IN);
   localparam int unsigned ACC_W = W_W + IDX_W;
   localparam int unsigned T_W   = $clog2(TRACE_MAX + 1);
   localparam int unsigned R_W   = $clog2(REFRAC + 2);
   localparam int unsigned V_MAX = 2**V_W - 1;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [ACC_W-1:0]           acc_q, acc_d;
   logic [V_W-1:0]             v_q, v_d, iext_q, iext_d;
   logic [N_IN-1:0]            pre_q, pre_d;
   logic                       learn_q, learn_d, spiked_q, spiked_d;
   logic [N_IN-1:0][W_W-1:0]   w_q, w_d;
   logic [N_IN-1:0][T_W-1:0]   pre_trace_q, pre_trace_d;
   logic [T_W-1:0]             post_trace_q, post_trace_d;
   logic [R_W-1:0]             refrac_q, refrac_d;
   logic [W_W-1:0]             w_upd;
   logic [V_W-1:0]             v_leak, vn;
   logic [V_W:0]               thr;
   logic                       last;

`ifdef LIF_ADAPT_THRESH_EN
   logic [V_W:0] thr_q, thr_d;
   assign thr = thr_q;
`else
   assign thr = (V_W+1)'(THRESH);
`endif

   assign last   = (idx_q == IDX_W'(N_IN - 1));
   assign v_leak = v_q - (v_q >> LEAK_SHIFT);
   assign vn     = V_W'(sat_add(32'(v_leak), 32'(acc_q) + 32'(iext_q), V_MAX));

   stdp_syn_update #(.W_W(W_W), .T_W(T_W)) u_syn (
      .w_i         (w_q[idx_q]),
      .pre_i       (pre_q[idx_q]),
      .pre_trace_i (pre_trace_q[idx_q]),
      .post_spk_i  (spiked_q),
      .post_trace_i(post_trace_q),
      .learn_en_i  (learn_q),
      .w_o         (w_upd)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      v_d          = v_q;
      iext_d       = iext_q;
      pre_d        = pre_q;
      learn_d      = learn_q;
      spiked_d     = spiked_q;
      w_d          = w_q;
      pre_trace_d  = pre_trace_q;
      post_trace_d = post_trace_q;
      refrac_d     = refrac_q;
`ifdef LIF_ADAPT_THRESH_EN
      thr_d        = thr_q;
`endif
      case (state_q)
         IDLE: if (step_valid) begin
            state_d = ACCUM;
            idx_d   = '0;
            acc_d   = '0;
            pre_d   = pre_spk_i;
            iext_d  = i_ext;
            learn_d = learn_en;
         end
         ACCUM: begin
            if (pre_q[idx_q]) acc_d = acc_q + ACC_W'(w_q[idx_q]);
            pre_trace_d[idx_q] = pre_q[idx_q] ? T_W'(TRACE_MAX)
                                              : T_W'(sat_dec(32'(pre_trace_q[idx_q])));
            idx_d   = last ? '0 : idx_q + IDX_W'(1);
            if (last) state_d = FIRE;
         end
         FIRE: begin
            state_d  = LEARN;
            spiked_d = 1'b0;
            if (refrac_q != '0) begin
               // Refractory: membrane clamped, threshold left alone.
               v_d          = '0;
               refrac_d     = refrac_q - R_W'(1);
               post_trace_d = T_W'(sat_dec(32'(post_trace_q)));
            end else if ({1'b0, vn} >= thr) begin
               v_d          = '0;
               spiked_d     = 1'b1;
               refrac_d     = R_W'(REFRAC);
               post_trace_d = T_W'(TRACE_MAX);
`ifdef LIF_ADAPT_THRESH_EN
               if (thr_q < (V_W+1)'(THRESH + 15)) thr_d = thr_q + (V_W+1)'(1);
`endif
            end else begin
               v_d          = vn;
               post_trace_d = T_W'(sat_dec(32'(post_trace_q)));
`ifdef LIF_ADAPT_THRESH_EN
               if (thr_q > (V_W+1)'(THRESH)) thr_d = thr_q - (V_W+1)'(1);
`endif
            end
         end
         LEARN: begin
            w_d[idx_q] = w_upd;
            idx_d      = last ? '0 : idx_q + IDX_W'(1);
            if (last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         acc_q        <= '0;
         v_q          <= '0;
         iext_q       <= '0;
         pre_q        <= '0;
         learn_q      <= 1'b0;
         spiked_q     <= 1'b0;
         for (int i = 0; i < N_IN; i++) w_q[i] <= W_W'(W_INIT);
         pre_trace_q  <= '0;
         post_trace_q <= '0;
         refrac_q     <= '0;
`ifdef LIF_ADAPT_THRESH_EN
         thr_q        <= (V_W+1)'(THRESH);
`endif
      end else if (ena) begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         v_q          <= v_d;
         iext_q       <= iext_d;
         pre_q        <= pre_d;
         learn_q      <= learn_d;
         spiked_q     <= spiked_d;
         w_q          <= w_d;
         pre_trace_q  <= pre_trace_d;
         post_trace_q <= post_trace_d;
         refrac_q     <= refrac_d;
`ifdef LIF_ADAPT_THRESH_EN
         thr_q        <= thr_d;
`endif
      end
   end

   assign step_ready = (state_q == IDLE);
   assign step_done  = (state_q == DONE);
   assign post_spk_o = (state_q == DONE) && spiked_q;
   assign v_mem_o    = v_q;
   assign w_o        = w_q[w_sel];

endmodule

// File: tb/tb_lif_stdp_layer.sv
// Self-checking bench for lif_stdp_layer (default parameters, adaptive threshold off).
module tb_lif_stdp_layer;

   typedef struct {
      logic [3:0]      pre;
      logic [7:0]      iext;
      logic            lrn;
      int              stall;
      logic [7:0]      v;
      logic            spk;
      logic [3:0][5:0] w;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n, ena, step_valid, learn_en;
   logic       step_ready, post_spk_o, step_done;
   logic [3:0] pre_spk_i;
   logic [7:0] i_ext, v_mem_o;
   logic [1:0] w_sel;
   logic [5:0] w_o;

   int   checks = 0;
   int   errors = 0;
   vec_t sb[$];
   vec_t tbl[14];

   always #5 clk = ~clk;

   lif_stdp_layer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .step_valid(step_valid),
      .step_ready(step_ready),
      .pre_spk_i (pre_spk_i),
      .i_ext     (i_ext),
      .learn_en  (learn_en),
      .w_sel     (w_sel),
      .w_o       (w_o),
      .v_mem_o   (v_mem_o),
      .post_spk_o(post_spk_o),
      .step_done (step_done)
   );

   function automatic vec_t mk(input logic [3:0] pre, input logic [7:0] iext, input logic lrn,
                               input int stall, input logic [7:0] v, input logic spk,
                               input int w3, input int w2, input int w1, input int w0);
      vec_t t;
      t.pre = pre; t.iext = iext; t.lrn = lrn; t.stall = stall; t.v = v; t.spk = spk;
      t.w = {6'(w3), 6'(w2), 6'(w1), 6'(w0)};
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_w(input string tag, input logic [3:0][5:0] w);
      for (int i = 0; i < 4; i++) begin
         w_sel = 2'(i);
         #1;
         chk($sformatf("%s_w%0d", tag, i), int'(w_o), int'(w[i]));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_v", int'(v_mem_o), 0);
      chk("rst_ready", int'(step_ready), 1);
      chk("rst_spk", int'(post_spk_o), 0);
      chk("rst_done", int'(step_done), 0);
      check_w("rst", {6'd16, 6'd16, 6'd16, 6'd16});
      rst_n = 1'b1;
   endtask

   task automatic run_step(input string tag, input vec_t t);
      vec_t e;
      int   lat;
      bit   got;
      sb.push_back(t);
      @(negedge clk);
      chk({tag, "_ready"}, int'(step_ready), 1);
      step_valid = 1'b1; pre_spk_i = t.pre; i_ext = t.iext; learn_en = t.lrn;
      @(posedge clk);
      #1 step_valid = 1'b0;
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_done) begin got = 1'b1; lat = c + 1; break; end
         ena = !(c < 1 + t.stall);
      end
      ena = 1'b1;
      e = sb.pop_front();
      if (!got) chk({tag, "_timeout"}, 0, 1);
      else begin
         chk({tag, "_lat"}, lat, 10 + e.stall);
         chk({tag, "_spk"}, int'(post_spk_o), int'(e.spk));
         chk({tag, "_v"}, int'(v_mem_o), int'(e.v));
         check_w(tag, e.w);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w0, dones, rdy, first;
      vec_t t;
      rst_n = 1'b0; ena = 1'b1; step_valid = 1'b0; learn_en = 1'b1;
      pre_spk_i = '0; i_ext = '0; w_sel = '0;

      tbl[0]  = mk(4'b0001,   0, 1, 0, 16, 0, 16, 16, 16, 16);
      tbl[1]  = mk(4'b1111,   0, 1, 0,  0, 1, 17, 17, 17, 17);
      tbl[2]  = mk(4'b1111,   0, 1, 0,  0, 0, 16, 16, 16, 16);
      tbl[3]  = mk(4'b1111,   0, 1, 0,  0, 0, 15, 15, 15, 15);
      tbl[4]  = mk(4'b0000,  10, 1, 0, 10, 0, 15, 15, 15, 15);
      tbl[5]  = mk(4'b0011,   5, 0, 3, 44, 0, 15, 15, 15, 15);
      tbl[6]  = mk(4'b0100,   0, 1, 0, 54, 0, 15, 15, 15, 15);
      tbl[7]  = mk(4'b0000, 200, 0, 0,  0, 1, 15, 15, 15, 15);
      tbl[8]  = mk(4'b1000,   0, 0, 0,  0, 0, 15, 15, 15, 15);
      tbl[9]  = mk(4'b1000,   0, 1, 0,  0, 0, 14, 15, 15, 15);
      tbl[10] = mk(4'b0001, 100, 1, 0,  0, 1, 15, 15, 15, 16);
      tbl[11] = mk(4'b0000,   0, 1, 0,  0, 0, 15, 15, 15, 16);
      tbl[12] = mk(4'b0000,   0, 1, 0,  0, 0, 15, 15, 15, 16);
      tbl[13] = mk(4'b0000,   3, 1, 0,  3, 0, 15, 15, 15, 16);

      do_reset();
      for (int i = 0; i < 14; i++) run_step($sformatf("vec%0d", i), tbl[i]);

      // Weight saturation: spike on input 0, then two quiet refractory steps.
      do_reset();
      w0 = 16;
      for (int n = 0; n < 50; n++) begin
         w0 = (w0 < 63) ? w0 + 1 : 63;
         run_step("sat_spk", mk(4'b0001, 255, 1, 0, 0, 1, 16, 16, 16, w0));
         run_step("sat_ref", mk(4'b0000,   0, 1, 0, 0, 0, 16, 16, 16, w0));
         run_step("sat_ref", mk(4'b0000,   0, 1, 0, 0, 0, 16, 16, 16, w0));
      end
      chk("sat_w0_cap", w0, 63);
      run_step("frozen", mk(4'b1111, 255, 0, 0, 0, 1, 16, 16, 16, 63));

      // Backpressure: valid held high for 33 cycles -> three handshakes.
      do_reset();
      dones = 0; rdy = 0; first = 0;
      @(negedge clk);
      step_valid = 1'b1; pre_spk_i = '0; i_ext = '0; learn_en = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (step_done) begin dones++; if (first == 0) first = k; end
         if (step_ready) rdy++;
      end
      step_valid = 1'b0;
      chk("bp_dones", dones, 3);
      chk("bp_ready_cycles", rdy, 3);
      chk("bp_first_done", first, 10);
      @(negedge clk);
      chk("bp_v", int'(v_mem_o), 0);

      // Reset in the middle of LEARN.
      do_reset();
      @(negedge clk);
      step_valid = 1'b1; pre_spk_i = 4'b1111; i_ext = '0; learn_en = 1'b1;
      @(posedge clk);
      #1 step_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      w_sel = 2'd0;
      #1 chk("midlearn_w0_before", int'(w_o), 17);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ready", int'(step_ready), 1);
      chk("midrst_done", int'(step_done), 0);
      chk("midrst_v", int'(v_mem_o), 0);
      check_w("midrst", {6'd16, 6'd16, 6'd16, 6'd16});
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (step_done) dones++;
      end
      chk("midrst_no_done", dones, 0);
      t = mk(4'b0001, 0, 1, 0, 16, 0, 16, 16, 16, 16);
      run_step("after_rst", t);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
